// File: rtl/truth_table_scanner_pkg.sv
// Shared types and sizing helpers for the truth-table scanner.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } tt_state_t;

    localparam int N_IN_MAX   = 6;
    localparam int SETTLE_MAX = 15;
    localparam int SETTLE_W   = 4;

    // Widths for the default 4-input build; parameterised blocks use the helpers.
    localparam int N_IN_DEF = 4;
    localparam int TT_W     = 1 << N_IN_DEF;
    localparam int CNT_W    = N_IN_DEF + 1;

    function automatic int tt_w(input int n);
        return 1 << n;
    endfunction

    function automatic int cnt_w(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Bundle between the scanner and whoever drives it. The master side also
// hosts the function under test, so it owns dut_y and consumes dut_in.
interface truth_table_scanner_if #(parameter int N_IN = 4);
    import tt_pkg::*;

    localparam int TBL_W = tt_w(N_IN);
    localparam int CW    = cnt_w(N_IN);

    logic             start;
    logic [TBL_W-1:0] expected;
    logic [N_IN-1:0]  dut_in;
    logic             dut_y;
    logic             busy;
    logic             done;
    logic [TBL_W-1:0] table_out;
    logic [TBL_W-1:0] mismatch_mask;
    logic [CW-1:0]    mismatch_count;
    logic             pass;

    modport master (
        output start, expected, dut_y,
        input  dut_in, busy, done, table_out, mismatch_mask, mismatch_count, pass
    );

    modport slave (
        input  start, expected, dut_y,
        output dut_in, busy, done, table_out, mismatch_mask, mismatch_count, pass
    );

endinterface

// File: rtl/truth_table_scanner_popcount.sv
// Combinational population count used for the mismatch tally.
module tt_popcount #(
    parameter int W  = 16,
    parameter int CW = 5
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);

    // Ripple sum of all set bits; W is at most 64 so this stays shallow enough.
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps every input combination of an external Boolean function, captures
// its truth table and compares it against a latched expected table.
//
// state  | meaning
// IDLE   | waiting for start, dut_in parked at 0
// APPLY  | dut_in = idx, waiting out the settle time
// SAMPLE | dut_in = idx, dut_y captured into work[idx] at the edge
// FINISH | one-cycle done pulse, results visible; start here chains a scan
module truth_table_scanner
    import tt_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input logic                 clk,
    input logic                 reset,
    truth_table_scanner_if.slave bus
);

    localparam int TBL_W = tt_w(N_IN);
    localparam int CW    = cnt_w(N_IN);

    localparam logic [N_IN-1:0]     IDX_LAST    = '1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = (SETTLE == 0) ? '0 : SETTLE_W'(SETTLE - 1);
    // With no settle time the APPLY slot collapses and each vector is a single SAMPLE cycle.
    localparam tt_state_t           FIRST_ST    = (SETTLE == 0) ? SAMPLE : APPLY;

    tt_state_t           state, state_nxt;
    logic [N_IN-1:0]     idx, idx_nxt;
    logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
    logic [TBL_W-1:0]    work, work_nxt;
    logic [TBL_W-1:0]    exp_q;
    logic [N_IN-1:0]     dut_in_q;
    logic [TBL_W-1:0]    table_q;
    logic [TBL_W-1:0]    mask_q;
    logic [CW-1:0]       count_q;
    logic                pass_q;
    logic                accept;
    logic                last_sample;
    logic [TBL_W-1:0]    diff;
    logic [CW-1:0]       pc_count;

    // Compare against the table including the bit being sampled this cycle,
    // so the results can be registered on the same edge that enters FINISH.
    assign diff = work_nxt ^ exp_q;

    tt_popcount #(
        .W  (TBL_W),
        .CW (CW)
    ) u_popcount (
        .bits  (diff),
        .count (pc_count)
    );

    // Next-state, index, settle and working-table logic.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        settle_nxt  = settle_cnt;
        work_nxt    = work;
        accept      = 1'b0;
        last_sample = 1'b0;
        case (state)
            IDLE, FINISH: begin
                if (state == FINISH) begin
                    state_nxt = IDLE;
                end
                if (bus.start) begin
                    accept     = 1'b1;
                    state_nxt  = FIRST_ST;
                    idx_nxt    = '0;
                    settle_nxt = '0;
                    work_nxt   = '0;
                end
            end
            APPLY: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_nxt = '0;
                    state_nxt  = SAMPLE;
                end else begin
                    settle_nxt = settle_cnt + SETTLE_W'(1);
                end
            end
            SAMPLE: begin
                work_nxt[idx] = bus.dut_y;
                if (idx == IDX_LAST) begin
                    last_sample = 1'b1;
                    state_nxt   = FINISH;
                end else begin
                    idx_nxt   = idx + N_IN'(1);
                    state_nxt = FIRST_ST;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sequencer state and the registered dut_in drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            work       <= '0;
            dut_in_q   <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            settle_cnt <= settle_nxt;
            work       <= work_nxt;
            dut_in_q   <= (state_nxt == APPLY || state_nxt == SAMPLE) ? idx_nxt : '0;
        end
    end

    // Expected-table latch and result registers; results clear on acceptance
    // except table_out, which holds until the next capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q   <= '0;
            table_q <= '0;
            mask_q  <= '0;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else if (accept) begin
            exp_q   <= bus.expected;
            mask_q  <= '0;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else if (last_sample) begin
            table_q <= work_nxt;
            mask_q  <= diff;
            count_q <= pc_count;
            pass_q  <= (pc_count == '0);
        end
    end

    assign bus.dut_in         = dut_in_q;
    assign bus.busy           = (state == APPLY) || (state == SAMPLE);
    assign bus.done           = (state == FINISH);
    assign bus.table_out      = table_q;
    assign bus.mismatch_mask  = mask_q;
    assign bus.mismatch_count = count_q;
    assign bus.pass           = pass_q;

endmodule
